// File: rtl/character_drawer_if.sv
// Pixel bus between the character drawer and the VGA adapter, plus the
// position-FSM state the drawer follows.
interface character_drawer_if;
  logic [3:0] CurrState;
  logic [7:0] X;
  logic [6:0] Y;
  logic [2:0] Colour;
  logic       Plot;
  logic       Busy;
  logic       Done;

  modport master (
    input  CurrState,
    output X, Y, Colour, Plot, Busy, Done
  );

  modport slave (
    output CurrState,
    input  X, Y, Colour, Plot, Busy, Done
  );
endinterface

// File: rtl/character_drawer.sv
// Renders the character sprite into the framebuffer, one pixel per clock:
// clear all lanes after reset, then erase/redraw whenever the settled lane moves.
module character_drawer #(
  parameter int         SPRITE_W   = 8,
  parameter int         SPRITE_H   = 8,
  parameter logic [6:0] Y_POS      = 7'd100,
  parameter logic [7:0] LANE_X0    = 8'd20,
  parameter logic [7:0] LANE_PITCH = 8'd40,
  parameter logic [2:0] BG_COLOUR  = 3'b000,
  parameter logic [2:0] FG_COLOUR  = 3'b111
) (
  input logic               Clock,
  input logic               Reset,
  character_drawer_if.master vga
);

  localparam int NUM_LANES = 4;
  localparam int CW = (SPRITE_W > 1) ? $clog2(SPRITE_W) : 1;
  localparam int RW = (SPRITE_H > 1) ? $clog2(SPRITE_H) : 1;
  localparam logic [CW-1:0] COL_LAST = CW'(SPRITE_W - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(SPRITE_H - 1);

  typedef enum logic [2:0] {
    S_CLEAR,
    S_IDLE,
    S_ERASE,
    S_DRAW,
    S_DONE
  } state_t;

  state_t        state, state_nx;
  logic [CW-1:0] col, col_nx;
  logic [RW-1:0] row, row_nx;
  logic [1:0]    clr_lane, clr_lane_nx;
  logic [1:0]    drawn_lane, drawn_lane_nx;
  logic [1:0]    target_lane, target_lane_nx;

  logic [NUM_LANES-1:0][7:0] lane_x;
  logic                      last_px;
  logic                      pass_active;
  logic                      new_lane;
  logic [1:0]                lane_sel;

  generate
    for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
      assign lane_x[g] = LANE_X0 + LANE_PITCH * 8'(g);
    end
  endgenerate

  assign last_px     = (col == COL_LAST) && (row == ROW_LAST);
  assign pass_active = (state == S_CLEAR) || (state == S_ERASE) || (state == S_DRAW);
  // Only settled lanes (0-3) that differ from what is on screen trigger a redraw.
  assign new_lane    = (vga.CurrState <= 4'd3) && (vga.CurrState[1:0] != drawn_lane);

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state       <= S_CLEAR;
      col         <= '0;
      row         <= '0;
      clr_lane    <= '0;
      drawn_lane  <= '0;
      target_lane <= '0;
    end else begin
      state       <= state_nx;
      col         <= col_nx;
      row         <= row_nx;
      clr_lane    <= clr_lane_nx;
      drawn_lane  <= drawn_lane_nx;
      target_lane <= target_lane_nx;
    end
  end

  always_comb begin
    state_nx       = state;
    col_nx         = col;
    row_nx         = row;
    clr_lane_nx    = clr_lane;
    drawn_lane_nx  = drawn_lane;
    target_lane_nx = target_lane;

    // Row-major scan; wrapping on the last pixel leaves counters at 0 for the next pass.
    if (pass_active) begin
      if (col == COL_LAST) begin
        col_nx = '0;
        row_nx = (row == ROW_LAST) ? '0 : row + RW'(1);
      end else begin
        col_nx = col + CW'(1);
      end
    end

    case (state)
      S_CLEAR: begin
        if (last_px) begin
          if (clr_lane == 2'd3) begin
            state_nx       = S_DRAW;
            target_lane_nx = 2'd0;
            clr_lane_nx    = 2'd0;
          end else begin
            clr_lane_nx = clr_lane + 2'd1;
          end
        end
      end
      S_IDLE: begin
        if (new_lane) begin
          target_lane_nx = vga.CurrState[1:0];
          state_nx       = S_ERASE;
        end
      end
      S_ERASE: begin
        if (last_px) state_nx = S_DRAW;
      end
      S_DRAW: begin
        if (last_px) begin
          drawn_lane_nx = target_lane;
          state_nx      = S_DONE;
        end
      end
      S_DONE:  state_nx = S_IDLE;
      default: state_nx = S_CLEAR;
    endcase
  end

  always_comb begin
    lane_sel   = 2'd0;
    vga.X      = '0;
    vga.Y      = '0;
    vga.Colour = '0;
    vga.Plot   = 1'b0;
    vga.Done   = 1'b0;
    vga.Busy   = (state != S_IDLE);

    case (state)
      S_CLEAR: begin
        lane_sel   = clr_lane;
        vga.Colour = BG_COLOUR;
        vga.Plot   = 1'b1;
      end
      S_ERASE: begin
        lane_sel   = drawn_lane;
        vga.Colour = BG_COLOUR;
        vga.Plot   = 1'b1;
      end
      S_DRAW: begin
        lane_sel   = target_lane;
        vga.Colour = FG_COLOUR;
        vga.Plot   = 1'b1;
      end
      S_DONE:  vga.Done = 1'b1;
      default: ;
    endcase

    if (vga.Plot) begin
      vga.X = lane_x[lane_sel] + 8'(col);
      vga.Y = Y_POS + 7'(row);
    end
  end

endmodule

// File: tb/tb_character_drawer.sv
// Directed plus randomized bench for character_drawer; expected pixel streams
// come from a lane-level model of clear/erase/draw passes.
module tb_character_drawer;
  localparam int W = 8, H = 8, X0 = 20, PITCH = 40, YP = 100;
  localparam int PASS = W * H;

  logic Clock = 1'b0;
  logic Reset = 1'b1;

  character_drawer_if bus();
  character_drawer dut (.Clock(Clock), .Reset(Reset), .vga(bus));

  always #5 Clock = ~Clock;

  int          total = 0;
  int          passes = 0;
  logic [1:0]  m_drawn = 2'd0;
  logic [17:0] exp_q[$];

  task automatic chk(input string tag, input int obs, input int exp_v);
    total++;
    assert (obs === exp_v) passes++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
  endtask

  function automatic void push_pass(input int lane, input int colour);
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++)
        exp_q.push_back({8'(X0 + lane * PITCH + c), 7'(YP + r), 3'(colour)});
  endfunction

  // Walks the DUT from cycle c0 until Done, matching every plotted pixel.
  task automatic collect(input string tag, input int c0, input int exp_done,
                         input int chg_at, input logic [3:0] chg_v,
                         input int chg2_at, input logic [3:0] chg2_v);
    int c = c0;
    int n = 0;
    int n_exp = exp_q.size();
    forever begin
      if (bus.Plot) begin
        if (exp_q.size() > 0) chk({tag, " pixel"}, int'({bus.X, bus.Y, bus.Colour}), int'(exp_q.pop_front()));
        else chk({tag, " extra plot"}, 1, 0);
        n++;
      end
      if (bus.Done) break;
      if (c >= exp_done + 10) begin
        chk({tag, " timeout"}, c, exp_done);
        break;
      end
      if (c == chg_at) bus.CurrState = chg_v;
      if (c == chg2_at) bus.CurrState = chg2_v;
      @(negedge Clock);
      c++;
    end
    chk({tag, " done cycle"}, c, exp_done);
    chk({tag, " busy at done"}, int'({bus.Busy, bus.Plot}), 2);
    chk({tag, " plot count"}, n, n_exp);
    exp_q.delete();
  endtask

  task automatic reset_seq(input int hold);
    bus.CurrState = 4'd0;
    Reset = 1'b1;
    for (int i = 0; i < hold; i++) begin
      @(negedge Clock);
      chk("reset pixel0", int'({bus.X, bus.Y, bus.Colour, bus.Plot, bus.Busy, bus.Done}),
          int'({8'd20, 7'd100, 3'd0, 1'b1, 1'b1, 1'b0}));
    end
    Reset = 1'b0;
    for (int l = 0; l < 4; l++) push_pass(l, 0);
    push_pass(0, 7);
    collect("reset seq", 0, 2 * 4 * PASS / 2 + PASS, -1, 4'd0, -1, 4'd0);
    m_drawn = 2'd0;
    @(negedge Clock);
    chk("post reset idle", int'({bus.Busy, bus.Plot, bus.Done}), 0);
  endtask

  // Called at an idle cycle; drives v and follows every redraw it causes.
  task automatic apply(input logic [3:0] v, input int chg_at, input logic [3:0] chg_v,
                       input int chg2_at, input logic [3:0] chg2_v);
    int a1 = chg_at, a2 = chg2_at;
    logic [1:0] tgt;
    bus.CurrState = v;
    forever begin
      @(negedge Clock);
      if (bus.CurrState <= 4'd3 && bus.CurrState[1:0] != m_drawn) begin
        tgt = bus.CurrState[1:0];
        push_pass(m_drawn, 0);
        push_pass(tgt, 7);
        collect("redraw", 1, 2 * PASS + 1, a1, chg_v, a2, chg2_v);
        a1 = -1;
        a2 = -1;
        m_drawn = tgt;
        @(negedge Clock);
        chk("idle after done", int'({bus.Busy, bus.Plot, bus.Done}), 0);
      end else begin
        chk("no redraw", int'({bus.Busy, bus.Plot, bus.Done}), 0);
        chk("drawn lane", int'(dut.drawn_lane), int'(m_drawn));
        break;
      end
    end
  endtask

  initial begin
    bus.CurrState = 4'd0;
    reset_seq(3);

    apply(4'd4, -1, 4'd0, -1, 4'd0);
    apply(4'd1, -1, 4'd0, -1, 4'd0);
    apply(4'd3, -1, 4'd0, -1, 4'd0);
    apply(4'd1, -1, 4'd0, -1, 4'd0);
    // 1->2 in flight while CurrState wanders 8 then 3; 3 is picked up afterwards.
    apply(4'd2, 70, 4'd8, 100, 4'd3);
    chk("drawn after chase", int'(dut.drawn_lane), 3);

    bus.CurrState = 4'd0;
    for (int c = 1; c <= 30; c++) begin
      @(negedge Clock);
      chk("abort erase", int'({bus.Plot, bus.Done, bus.Colour}), int'({1'b1, 1'b0, 3'd0}));
    end
    chk("abort 30th px", int'({bus.X, bus.Y}), int'({8'd145, 7'd103}));
    reset_seq(1);

    apply(4'd12, -1, 4'd0, -1, 4'd0);
    repeat (3) begin
      @(negedge Clock);
      chk("invalid hold", int'({bus.Busy, bus.Plot}), 0);
    end

    for (int i = 0; i < 20; i++) begin
      logic [3:0] v, cv;
      int at;
      v  = 4'($urandom_range(0, 15));
      cv = 4'($urandom_range(0, 15));
      at = ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, 2 * PASS)) : -1;
      apply(v, at, cv, -1, 4'd0);
    end

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule
